// File: rtl/minisys_if.sv
// minisys_if: instruction-fetch stage for the minisys pipeline.
// Holds the PC, a one-entry skid buffer and the IF/ID register. It issues
// requests to an instruction memory that may answer in the same cycle or
// later, and it handles stalls and branch/jump redirects.
//
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   load_use, MDPause         stall requests from ID
//   jumpI, pc_jumpI           jump redirect request and target
//   branchE, branch_targetE   taken-branch redirect and target (wins over jump)
//   imem_req, imem_addr       instruction memory request and byte address
//   imem_ack, imem_rdata      memory response
//   instrD, pcplus4D          IF/ID register outputs
module minisys_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        load_use,
  input  logic        MDPause,
  input  logic        jumpI,
  input  logic [31:0] pc_jumpI,
  input  logic        branchE,
  input  logic [31:0] branch_targetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] skidInstr, skidInstrNext;
  logic [31:0] skidPc4, skidPc4Next;
  logic        skidValid, skidValidNext;
  logic [31:0] instrNext, pc4Next;

  logic        stall, redirect;
  logic [31:0] target, pcPlus4;

  assign stall    = load_use | MDPause;
  assign redirect = branchE | jumpI;
  assign target   = (branchE ? branch_targetE : pc_jumpI) & 32'hFFFF_FFFC;
  assign pcPlus4  = pc + 32'd4;

  assign imem_addr = pc;
  // Gated by clrn so no request is visible while reset is held, even though
  // the state register already sits in FETCH.
  assign imem_req  = clrn && (state != HOLD);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      skidInstr <= '0;
      skidPc4   <= '0;
      skidValid <= 1'b0;
      instrD    <= '0;
      pcplus4D  <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      skidInstr <= skidInstrNext;
      skidPc4   <= skidPc4Next;
      skidValid <= skidValidNext;
      instrD    <= instrNext;
      pcplus4D  <= pc4Next;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    skidInstrNext = skidInstr;
    skidPc4Next   = skidPc4;
    skidValidNext = skidValid;
    instrNext     = instrD;
    pc4Next       = pcplus4D;

    case (state)
      FETCH: begin
        if (redirect) begin
          pcNext        = target;
          instrNext     = '0;
          pc4Next       = '0;
          skidValidNext = 1'b0;
          // An unanswered request is still in flight and must be drained.
          stateNext     = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          pcNext = pcPlus4;
          if (!stall) begin
            instrNext = imem_rdata;
            pc4Next   = pcPlus4;
          end else begin
            skidInstrNext = imem_rdata;
            skidPc4Next   = pcPlus4;
            skidValidNext = 1'b1;
            stateNext     = HOLD;
          end
        end else if (!stall) begin
          instrNext = '0;
          pc4Next   = '0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pcNext        = target;
          instrNext     = '0;
          pc4Next       = '0;
          skidValidNext = 1'b0;
          stateNext     = FETCH;
        end else if (!stall) begin
          instrNext     = skidValid ? skidInstr : '0;
          pc4Next       = skidValid ? skidPc4   : '0;
          skidValidNext = 1'b0;
          stateNext     = FETCH;
        end
      end

      DROP: begin
        if (redirect) begin
          pcNext    = target;
          instrNext = '0;
          pc4Next   = '0;
        end else if (imem_ack) begin
          // This ack belongs to the abandoned request; PC is kept so the
          // target gets requested again from FETCH.
          stateNext = FETCH;
        end
      end

      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: tb/tb_minisys_if.sv
module tb_minisys_if;

  logic        clk = 1'b0;
  logic        clrn;
  logic        load_use, MDPause, jumpI, branchE;
  logic [31:0] pc_jumpI, branch_targetE;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, pcplus4D;
  logic        ackEn;

  int unsigned errorCount = 0;
  int unsigned checkCount = 0;

  minisys_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .load_use       (load_use),
    .MDPause        (MDPause),
    .jumpI          (jumpI),
    .pc_jumpI       (pc_jumpI),
    .branchE        (branchE),
    .branch_targetE (branch_targetE),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instrD         (instrD),
    .pcplus4D       (pcplus4D)
  );

  always #5 clk = ~clk;

  // Zero-wait memory returning addr|1 whenever acks are enabled.
  assign imem_ack   = imem_req & ackEn;
  assign imem_rdata = imem_ack ? (imem_addr | 32'h1) : 32'hDEAD_BEEF;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0; load_use = 0; MDPause = 0; jumpI = 0; branchE = 0;
    pc_jumpI = '0; branch_targetE = '0; ackEn = 1'b1;
    step(); step();
    checkVal("rst_req",   {31'b0, imem_req}, 32'h0);
    checkVal("rst_instr", instrD,   32'h0);
    checkVal("rst_pc4",   pcplus4D, 32'h0);
    checkVal("rst_addr",  imem_addr, 32'h0);

    clrn = 1'b1;
    #1;
    checkVal("first_req",  {31'b0, imem_req}, 32'h1);
    checkVal("first_addr", imem_addr, 32'h0);

    // Streaming, one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      step();
      checkVal("seq_instr", instrD,   32'(4 * i + 1));
      checkVal("seq_pc4",   pcplus4D, 32'(4 * i + 4));
    end

    // Two-cycle load-use stall with acks still flowing.
    load_use = 1'b1;
    step();
    checkVal("stall1_instr", instrD, 32'hD);
    checkVal("stall1_req",   {31'b0, imem_req}, 32'h0);
    checkVal("stall1_addr",  imem_addr, 32'h14);
    step();
    checkVal("stall2_instr", instrD, 32'hD);
    checkVal("stall2_pc4",   pcplus4D, 32'h10);
    checkVal("stall2_req",   {31'b0, imem_req}, 32'h0);
    load_use = 1'b0;
    step();
    checkVal("skid_instr", instrD,   32'h11);
    checkVal("skid_pc4",   pcplus4D, 32'h14);
    checkVal("skid_req",   {31'b0, imem_req}, 32'h1);
    step();
    checkVal("resume_instr", instrD,   32'h15);
    checkVal("resume_pc4",   pcplus4D, 32'h18);

    // No ack, no stall -> bubble, PC held. No ack, stall -> IF/ID held.
    ackEn = 1'b0;
    step();
    checkVal("bubble_instr", instrD, 32'h0);
    checkVal("bubble_addr",  imem_addr, 32'h18);
    ackEn = 1'b1;
    step();
    checkVal("after_bubble", instrD, 32'h19);
    ackEn = 1'b0; MDPause = 1'b1;
    step();
    checkVal("noack_stall", instrD, 32'h19);
    ackEn = 1'b1; MDPause = 1'b0;
    step();
    checkVal("after_nsa", instrD, 32'h1D);

    // Jump while request outstanding -> DROP, first ack discarded.
    ackEn = 1'b0; jumpI = 1'b1; pc_jumpI = 32'h0000_0103;
    step();
    jumpI = 1'b0;
    checkVal("jmp_instr", instrD,   32'h0);
    checkVal("jmp_pc4",   pcplus4D, 32'h0);
    checkVal("jmp_addr",  imem_addr, 32'h100);
    checkVal("jmp_req",   {31'b0, imem_req}, 32'h1);
    ackEn = 1'b1;
    step();
    checkVal("drop_instr", instrD, 32'h0);
    checkVal("drop_addr",  imem_addr, 32'h100);
    step();
    checkVal("tgt_instr", instrD,   32'h101);
    checkVal("tgt_pc4",   pcplus4D, 32'h104);

    // Branch and jump together under MDPause: branch wins, NOP injected.
    branchE = 1'b1; branch_targetE = 32'h40; jumpI = 1'b1; pc_jumpI = 32'h80; MDPause = 1'b1;
    step();
    branchE = 1'b0; jumpI = 1'b0; MDPause = 1'b0;
    checkVal("br_addr",  imem_addr, 32'h40);
    checkVal("br_instr", instrD,   32'h0);
    checkVal("br_pc4",   pcplus4D, 32'h0);
    step();
    checkVal("br_next_instr", instrD,   32'h41);
    checkVal("br_next_pc4",   pcplus4D, 32'h44);

    // PC+4 wraps.
    jumpI = 1'b1; pc_jumpI = 32'hFFFF_FFFC;
    step();
    jumpI = 1'b0;
    checkVal("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    checkVal("wrap_instr", instrD,   32'hFFFF_FFFD);
    checkVal("wrap_pc4",   pcplus4D, 32'h0);
    checkVal("wrap_addr",  imem_addr, 32'h0);

    // Reset pulse while in DROP.
    ackEn = 1'b0; jumpI = 1'b1; pc_jumpI = 32'h200;
    step();
    jumpI = 1'b0;
    checkVal("pre_rst_addr", imem_addr, 32'h200);
    clrn = 1'b0;
    #1;
    checkVal("mid_rst_req",   {31'b0, imem_req}, 32'h0);
    checkVal("mid_rst_addr",  imem_addr, 32'h0);
    checkVal("mid_rst_instr", instrD, 32'h0);
    step();
    clrn = 1'b1; ackEn = 1'b1;
    #1;
    checkVal("rel_req",  {31'b0, imem_req}, 32'h1);
    checkVal("rel_addr", imem_addr, 32'h0);
    step();
    checkVal("rel_instr", instrD,   32'h1);
    checkVal("rel_pc4",   pcplus4D, 32'h4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/minisys_if.md
MINISYS_IF -- requirements
Module: minisys_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 load_use  input  1  hazard stall request from ID.
REQ-005 MDPause  input  1  multiply/divide stall request from ID.
REQ-006 jumpI  input  1  jump redirect request.
REQ-007 pc_jumpI  input  32  jump target address.
REQ-008 branchE  input  1  taken-branch redirect request.
REQ-009 branch_targetE  input  32  branch target address.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  32  instruction memory word address (byte address, bits[1:0]=0).
REQ-012 imem_ack  input  1  read data valid; may be asserted in the same cycle as imem_req (zero-wait) or later.
REQ-013 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-014 instrD  output  32  IF/ID register: instruction for ID.
REQ-015 pcplus4D  output  32  IF/ID register: fetch PC + 4.

Function
REQ-016 The block SHALL hold the PC register, a one-entry skid buffer (instruction plus its PC+4), the IF/ID register, and a 3-state FSM: FETCH, HOLD, DROP.
REQ-017 stall = load_use | MDPause; redirect = branchE | jumpI; target = branch_targetE if branchE=1, else pc_jumpI; target bits[1:0] SHALL be forced to 0.
REQ-018 imem_addr SHALL equal PC; imem_req SHALL be 1 only in FETCH and DROP.
REQ-019 FETCH, imem_ack=1, no stall, no redirect: IF/ID <= {imem_rdata, PC+4}; PC <= PC+4; remain in FETCH.
REQ-020 FETCH, imem_ack=1, stall=1, no redirect: IF/ID held; skid <= {imem_rdata, PC+4}; PC <= PC+4; go to HOLD.
REQ-021 FETCH, imem_ack=0: PC held; IF/ID held if stall=1, else IF/ID <= NOP bubble (instrD=32'h0, pcplus4D=32'h0).
REQ-022 HOLD: imem_req=0; while stall=1 hold everything; on the first cycle with stall=0, IF/ID <= skid and go to FETCH.
REQ-023 A redirect in any state SHALL have priority over stall: PC <= target and IF/ID <= NOP bubble on the same edge; the skid entry SHALL be discarded.
REQ-024 Redirect in FETCH with imem_ack=1, or in HOLD: the returned data SHALL be discarded and the next state SHALL be FETCH.
REQ-025 Redirect in FETCH with imem_ack=0: the next state SHALL be DROP, since the outstanding request must drain.
REQ-026 DROP: imem_addr SHALL equal the new PC; the first imem_ack SHALL be discarded without updating IF/ID; the next state SHALL then be FETCH and the PC SHALL be unchanged, so that the target is re-requested.
REQ-027 A further redirect while in DROP SHALL update the PC and remain in DROP.
REQ-028 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-029 With zero-wait memory and no stall, throughput SHALL be one instruction per cycle, with 1-cycle latency from request to instrD.
REQ-030 If branchE and jumpI are both 1, branchE SHALL win.

Reset
REQ-031 While clrn=0: PC=RESET_PC; FSM=FETCH; skid empty; instrD=32'h0; pcplus4D=32'h0; imem_req=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; after release the block SHALL treat any late imem_ack as belonging to the RESET_PC request.
REQ-033 The first imem_req SHALL occur in the first cycle after clrn rises, with imem_addr=RESET_PC.

Verification
REQ-034 Zero-wait memory returning addr|1, no stall, 4 cycles -> instrD = 1, 5, 9, D; pcplus4D = 4, 8, C, 10.
REQ-035 load_use=1 for 2 cycles while acks continue -> IF/ID holds the same value, one word is captured in skid, imem_req=0 in HOLD, and the sequence resumes with no word lost or duplicated.
REQ-036 jumpI=1, pc_jumpI=32'h0000_0103 with ack pending (imem_ack=0) -> IF/ID=NOP, DROP entered, first ack discarded, next instrD from address 32'h100.
REQ-037 branchE=1 (target 32'h40) and jumpI=1 (target 32'h80) together with MDPause=1 -> PC=32'h40, IF/ID=NOP on the next edge.
REQ-038 PC=32'hFFFF_FFFC, ack -> pcplus4D=32'hFFFF_FFFC+4=32'h0, next imem_addr=32'h0.
REQ-039 clrn pulsed low during DROP -> outputs reach reset values immediately, and the next request is to RESET_PC.
